// File: rtl/fire_arb_pkg.sv
// Shared definitions for the fire arbiter: FSM state encoding and default
// parameter values.
package fire_arb_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DRAIN   = 2'd1,
        DONE    = 2'd2
    } arb_state_t;

    localparam int DEF_NUMNEURONS = 4;
    localparam int DEF_TAGBITS    = 2;
    localparam int DEF_COUNTBITS  = 8;

endpackage

// File: rtl/fire_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority encoder. Returns the first set
// request bit found scanning ptr, ptr+1, ... and wrapping at NUMNEURONS-1.
// NUMNEURONS need not be a power of two.
module rr_pick
    import fire_arb_pkg::*;
#(
    parameter int NUMNEURONS = DEF_NUMNEURONS,
    parameter int TAGBITS    = DEF_TAGBITS
) (
    input  logic [NUMNEURONS-1:0] req,
    input  logic [TAGBITS-1:0]    ptr,
    output logic                  valid,
    output logic [TAGBITS-1:0]    idx
);

    int cand_s;

    // Scan all candidates starting at ptr; the first hit is kept.
    always_comb begin
        valid  = 1'b0;
        idx    = '0;
        cand_s = 0;
        for (int off = 0; off < NUMNEURONS; off++) begin
            // Modulo keeps the index in range even if ptr were ever out of range.
            cand_s = (int'(ptr) + off) % NUMNEURONS;
            if (!valid && req[cand_s]) begin
                valid = 1'b1;
                idx   = TAGBITS'(cand_s);
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/fire_arbiter.sv
// fire_arbiter: collects per-neuron fire events and serialises them, one tag
// per cycle, into the fire FIFO using round-robin priority. After step_end it
// drains all pending fires, then pulses step_done for one cycle.
// Optional macro FIRE_ARB_STATS_EN adds a saturating per-timestep spike
// counter (spike_count) and its COUNTBITS parameter.
module fire_arbiter
    import fire_arb_pkg::*;
#(
    parameter int NUMNEURONS = DEF_NUMNEURONS,
    parameter int TAGBITS    = DEF_TAGBITS
`ifdef FIRE_ARB_STATS_EN
    ,
    parameter int COUNTBITS  = DEF_COUNTBITS
`endif
) (
    input  logic                  clk,
    input  logic                  asyn_reset,
    input  logic [NUMNEURONS-1:0] fire_vec,
    input  logic                  step_end,
    input  logic                  fifo_full,
    output logic                  fifo_enq,
    output logic [TAGBITS-1:0]    fifo_tag,
    output logic                  step_done,
    output logic                  overflow
`ifdef FIRE_ARB_STATS_EN
    ,
    output logic [COUNTBITS-1:0]  spike_count
`endif
);

    logic [NUMNEURONS-1:0] pending_r;
    logic [TAGBITS-1:0]    rr_ptr_r;
    arb_state_t            state_r;
    logic                  step_done_r;
    logic                  overflow_r;

    logic                  pick_valid_s;
    logic [TAGBITS-1:0]    pick_idx_s;
    logic                  grant_valid_s;
    logic [NUMNEURONS-1:0] clr_s;
    logic [NUMNEURONS-1:0] pending_nxt_s;
    logic                  coalesce_s;
    logic [TAGBITS-1:0]    rr_ptr_nxt_s;

    rr_pick #(
        .NUMNEURONS (NUMNEURONS),
        .TAGBITS    (TAGBITS)
    ) u_rr_pick (
        .req   (pending_r),
        .ptr   (rr_ptr_r),
        .valid (pick_valid_s),
        .idx   (pick_idx_s)
    );

    // Grant decision, pending update, pointer advance and coalesce detection.
    always_comb begin
        grant_valid_s = pick_valid_s && !fifo_full;
        clr_s         = '0;
        rr_ptr_nxt_s  = rr_ptr_r;
        for (int i = 0; i < NUMNEURONS; i++) begin
            clr_s[i] = grant_valid_s && (pick_idx_s == TAGBITS'(i));
        end
        if (grant_valid_s) begin
            if (pick_idx_s == TAGBITS'(NUMNEURONS - 1)) begin
                rr_ptr_nxt_s = '0;
            end else begin
                rr_ptr_nxt_s = pick_idx_s + TAGBITS'(1);
            end
        end else begin
            rr_ptr_nxt_s = rr_ptr_r;
        end
        // A fire arriving on the edge its own bit is granted re-arms the bit,
        // so it is neither lost nor counted as a coalesce.
        pending_nxt_s = (pending_r & ~clr_s) | fire_vec;
        coalesce_s    = |(fire_vec & pending_r & ~clr_s);
    end

    // FIFO write port is driven straight from the grant.
    always_comb begin
        fifo_enq = grant_valid_s;
        if (grant_valid_s) begin
            fifo_tag = pick_idx_s;
        end else begin
            fifo_tag = '0;
        end
    end

    // Pending bits, round-robin pointer and sticky overflow flag.
    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            pending_r  <= '0;
            rr_ptr_r   <= '0;
            overflow_r <= 1'b0;
        end else begin
            pending_r  <= pending_nxt_s;
            rr_ptr_r   <= rr_ptr_nxt_s;
            overflow_r <= overflow_r | coalesce_s;
        end
    end

    // Timestep sequencer: COLLECT -> DRAIN on step_end, DRAIN -> DONE once
    // idle, DONE -> COLLECT unconditionally; step_done registered with state.
    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            state_r     <= COLLECT;
            step_done_r <= 1'b0;
        end else begin
            case (state_r)
                COLLECT: begin
                    step_done_r <= 1'b0;
                    if (step_end) begin
                        state_r <= DRAIN;
                    end else begin
                        state_r <= COLLECT;
                    end
                end
                DRAIN: begin
                    if ((pending_r == '0) && (fire_vec == '0)) begin
                        state_r     <= DONE;
                        step_done_r <= 1'b1;
                    end else begin
                        state_r     <= DRAIN;
                        step_done_r <= 1'b0;
                    end
                end
                DONE: begin
                    state_r     <= COLLECT;
                    step_done_r <= 1'b0;
                end
                default: begin
                    state_r     <= COLLECT;
                    step_done_r <= 1'b0;
                end
            endcase
        end
    end

    assign step_done = step_done_r;
    assign overflow  = overflow_r;

`ifdef FIRE_ARB_STATS_EN
    logic [COUNTBITS-1:0] spike_count_r;

    // Saturating count of granted tags, cleared when leaving DONE.
    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            spike_count_r <= '0;
        end else if (state_r == DONE) begin
            spike_count_r <= '0;
        end else if (grant_valid_s && (spike_count_r != '1)) begin
            spike_count_r <= spike_count_r + COUNTBITS'(1);
        end else begin
            spike_count_r <= spike_count_r;
        end
    end

    assign spike_count = spike_count_r;
`endif

endmodule

// File: tb/tb_fire_arbiter.sv
// Self-checking bench for fire_arbiter: stimulus drives a behavioural model
// that queues one expected output record per cycle; a monitor on the falling
// edge pops and compares each record against the DUT.
module tb_fire_arbiter;

    localparam int N  = 4;
    localparam int TB = 2;
    localparam int CB = 8;

    logic          clk = 1'b0;
    logic          asyn_reset;
    logic [N-1:0]  fire_vec;
    logic          step_end;
    logic          fifo_full;
    logic          fifo_enq;
    logic [TB-1:0] fifo_tag;
    logic          step_done;
    logic          overflow;
`ifdef FIRE_ARB_STATS_EN
    logic [CB-1:0] spike_count;
`endif

    fire_arbiter #(.NUMNEURONS(N), .TAGBITS(TB)
`ifdef FIRE_ARB_STATS_EN
        , .COUNTBITS(CB)
`endif
    ) dut (
        .clk        (clk),
        .asyn_reset (asyn_reset),
        .fire_vec   (fire_vec),
        .step_end   (step_end),
        .fifo_full  (fifo_full),
        .fifo_enq   (fifo_enq),
        .fifo_tag   (fifo_tag),
        .step_done  (step_done),
        .overflow   (overflow)
`ifdef FIRE_ARB_STATS_EN
        , .spike_count (spike_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit enq;
        int tag;
        bit done;
        bit ovf;
        int cnt;
    } rec_t;

    rec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: a set of waiting neurons, a next-priority index,
    // a phase number (0 collect, 1 drain, 2 done), the sticky flag and count.
    bit m_pend[N];
    int m_ptr;
    int m_phase;
    bit m_ovf;
    int m_cnt;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
        m_ptr = 0; m_phase = 0; m_ovf = 1'b0; m_cnt = 0;
    endtask

    // Drive one cycle of inputs, queue what the outputs must be this cycle,
    // then advance the model to the state after the next rising edge.
    task automatic cycle(input logic [N-1:0] f, input logic se, input logic full);
        rec_t r;
        bit any;
        bit gv;
        bit granted;
        int k;
        int j;
        fire_vec = f; step_end = se; fifo_full = full;
        any = 1'b0; k = 0;
        for (int off = 0; off < N; off++) begin
            j = (m_ptr + off) % N;
            if (!any && m_pend[j]) begin any = 1'b1; k = j; end
        end
        gv = any && !full;
        r.enq  = gv;
        r.tag  = gv ? k : 0;
        r.done = (m_phase == 2);
        r.ovf  = m_ovf;
        r.cnt  = m_cnt;
        exp_q.push_back(r);
        for (int i = 0; i < N; i++) begin
            granted = gv && (k == i);
            if (f[i] && m_pend[i] && !granted) m_ovf = 1'b1;
            m_pend[i] = f[i] || (m_pend[i] && !granted);
        end
        if (gv) m_ptr = (k + 1) % N;
        if (m_phase == 2) m_cnt = 0;
        else if (gv && m_cnt < (1 << CB) - 1) m_cnt++;
        case (m_phase)
            0: if (se) m_phase = 1;
            1: if (!any && f == '0) m_phase = 2;
            2: m_phase = 0;
            default: m_phase = 0;
        endcase
        @(posedge clk); #1;
    endtask

    // Monitor: compare the DUT outputs against the oldest queued record.
    initial begin
        rec_t r;
        forever begin
            @(negedge clk);
            if (!asyn_reset && exp_q.size() > 0) begin
                r = exp_q.pop_front();
                chk("fifo_enq",  int'(fifo_enq),  int'(r.enq));
                chk("fifo_tag",  int'(fifo_tag),  r.tag);
                chk("step_done", int'(step_done), int'(r.done));
                chk("overflow",  int'(overflow),  int'(r.ovf));
`ifdef FIRE_ARB_STATS_EN
                chk("spike_count", int'(spike_count), r.cnt);
`endif
            end
        end
    end

    initial begin
        asyn_reset = 1'b1; fire_vec = '0; step_end = 1'b0; fifo_full = 1'b0;
        model_reset();
        #2;
        chk("reset_enq",  int'(fifo_enq),  0);
        chk("reset_tag",  int'(fifo_tag),  0);
        chk("reset_done", int'(step_done), 0);
        chk("reset_ovf",  int'(overflow),  0);
        @(posedge clk); #1;
        asyn_reset = 1'b0;

        // All four fire at once: tags 0,1,2,3 on consecutive cycles.
        cycle(4'b1111, 1'b0, 1'b0);
        repeat (5) cycle(4'b0000, 1'b0, 1'b0);

        // Grant tag 1 (pointer moves to 2) with 0 and 3 waiting: 3 then 0.
        cycle(4'b0010, 1'b0, 1'b0);
        cycle(4'b1001, 1'b0, 1'b0);
        repeat (3) cycle(4'b0000, 1'b0, 1'b0);

        // Collision: neuron 1 fires again on the edge it is granted.
        cycle(4'b0010, 1'b0, 1'b0);
        cycle(4'b0010, 1'b0, 1'b0);
        repeat (3) cycle(4'b0000, 1'b0, 1'b0);

        // Stall under full, neuron 2 keeps firing -> coalesce, then release.
        cycle(4'b0101, 1'b0, 1'b1);
        repeat (4) cycle(4'b0100, 1'b0, 1'b1);
        repeat (4) cycle(4'b0000, 1'b0, 1'b0);

        // Drain with three fires pending, then step_done.
        cycle(4'b0111, 1'b0, 1'b1);
        cycle(4'b0000, 1'b1, 1'b1);
        repeat (7) cycle(4'b0000, 1'b0, 1'b0);

        // Idle step: minimum step_end -> step_done latency.
        cycle(4'b0000, 1'b1, 1'b0);
        repeat (4) cycle(4'b0000, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a drain with 1010 pending.
        cycle(4'b1010, 1'b0, 1'b1);
        cycle(4'b0000, 1'b1, 1'b1);
        cycle(4'b1000, 1'b0, 1'b1);
        fifo_full = 1'b0; fire_vec = '0; step_end = 1'b0;
        asyn_reset = 1'b1;
        #1;
        chk("midrst_enq",  int'(fifo_enq),  0);
        chk("midrst_done", int'(step_done), 0);
        chk("midrst_ovf",  int'(overflow),  0);
        exp_q.delete();
        model_reset();
        @(posedge clk); #1;
        asyn_reset = 1'b0;
        repeat (4) cycle(4'b0000, 1'b0, 1'b0);

        // Randomised traffic.
        for (int n = 0; n < 400; n++) begin
            logic [N-1:0] f;
            f = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            cycle(f, ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0));
        end
        repeat (12) cycle(4'b0000, 1'b0, 1'b0);

        // Bounded wait for the monitor to consume every queued record.
        for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(posedge clk);
        chk("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
